// File: rtl/ap_ctrl_perf_monitor_if.sv
// Handshake, control and readout bundle for ap_ctrl_perf_monitor.
// The monitor side uses the slave modport; the driver side uses master.
interface ap_ctrl_perf_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic              finish;
  logic              rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [2:0]        rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] timeout;
  logic              frozen;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish, rd_en, rd_ch, rd_sel,
    input  rd_data, rd_valid, busy, timeout, frozen
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, finish, rd_en, rd_ch, rd_sel,
    output rd_data, rd_valid, busy, timeout, frozen
  );
endinterface

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl handshake performance monitor: per-channel latency,
// II, stall and timeout statistics with a registered select readout.
module ap_ctrl_ch_mon #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ready,
  input  logic                  done,
  input  logic                  cont,
  input  logic                  finish,
  output logic [7:0][CNT_W-1:0] stats,
  output logic                  busy,
  output logic                  timeout
);
  typedef enum logic [1:0] {IDLE, BUSY, WAIT_CONT} state_t;

  localparam logic [CNT_W-1:0]  ONES = '1;
  localparam logic [CNT_W+31:0] TO_X = (CNT_W+32)'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] lat_cnt, ii_cnt, smp;
  logic [CNT_W-1:0] txn_cnt, lat_last, lat_min, lat_max, lat_sum, ii_min, ii_max, stall_cnt;
  logic             ii_seen, rec, accept, to_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ONES) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? ONES : s[CNT_W-1:0];
  endfunction

  // Start and done in the same IDLE cycle is a zero-latency sample.
  always_comb begin
    rec = 1'b0;
    smp = lat_cnt;
    case (state)
      IDLE: if (start && done) begin
        rec = 1'b1;
        smp = '0;
      end
      BUSY:    rec = done;
      default: rec = 1'b0;
    endcase
  end

  assign accept = start && ready;
  assign to_hit = (TIMEOUT != 0) && (state == BUSY) && ({32'd0, lat_cnt} == TO_X);
  assign busy   = (state != IDLE);
  assign stats  = {stall_cnt, ii_max, ii_min, lat_sum, lat_max, lat_min, lat_last, txn_cnt};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      ii_cnt    <= '0;
      ii_seen   <= 1'b0;
      timeout   <= 1'b0;
      txn_cnt   <= '0;
      lat_last  <= '0;
      lat_min   <= ONES;
      lat_max   <= '0;
      lat_sum   <= '0;
      ii_min    <= ONES;
      ii_max    <= '0;
      stall_cnt <= '0;
    end else begin
      // The FSM keeps tracking while frozen so it stays in step with the handshake.
      case (state)
        IDLE: if (start) begin
          lat_cnt <= CNT_W'(1);
          if (!done)     state <= BUSY;
          else if (!cont) state <= WAIT_CONT;
        end
        BUSY: begin
          lat_cnt <= sat_inc(lat_cnt);
          if (done) state <= cont ? IDLE : WAIT_CONT;
        end
        WAIT_CONT: if (cont) state <= IDLE;
        default:   state <= IDLE;
      endcase

      if (!finish) begin
        if (rec) begin
          txn_cnt  <= sat_inc(txn_cnt);
          lat_last <= smp;
          lat_sum  <= sat_add(lat_sum, smp);
          if (smp < lat_min) lat_min <= smp;
          if (smp > lat_max) lat_max <= smp;
        end
        if (state == WAIT_CONT && !cont) stall_cnt <= sat_inc(stall_cnt);
        if (to_hit) timeout <= 1'b1;
        // ii_cnt restarts at 1 so it equals the cycle distance at the next accept.
        if (accept) begin
          ii_cnt  <= CNT_W'(1);
          ii_seen <= 1'b1;
          if (ii_seen) begin
            if (ii_cnt < ii_min) ii_min <= ii_cnt;
            if (ii_cnt > ii_max) ii_max <= ii_cnt;
          end
        end else begin
          ii_cnt <= sat_inc(ii_cnt);
        end
      end
    end
  end
endmodule

module ap_ctrl_perf_monitor #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  ap_ctrl_perf_monitor_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0][7:0][CNT_W-1:0] stats;
  logic [NUM_CH-1:0]                 busy_v, timeout_v;
  logic [CNT_W-1:0]                  rd_mux, rd_data;
  logic                              rd_valid, frozen;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ap_ctrl_ch_mon #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .start   (bus.ap_start[c]),
      .ready   (bus.ap_ready[c]),
      .done    (bus.ap_done[c]),
      .cont    (bus.ap_continue[c]),
      .finish  (bus.finish),
      .stats   (stats[c]),
      .busy    (busy_v[c]),
      .timeout (timeout_v[c])
    );
  end

  // Out-of-range channels match no entry and read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (bus.rd_ch == CH_W'(c)) rd_mux = stats[c][bus.rd_sel];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      frozen   <= 1'b0;
    end else begin
      rd_valid <= bus.rd_en;
      frozen   <= bus.finish;
      if (bus.rd_en) rd_data <= rd_mux;
    end
  end

  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.busy     = busy_v;
  assign bus.timeout  = timeout_v;
  assign bus.frozen   = frozen;
endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed plus randomized bench for ap_ctrl_perf_monitor against a
// cycle-stamp reference model (latency/II as cycle differences, clamped on read).
module tb_ap_ctrl_perf_monitor;
  localparam int     NCH  = 2;
  localparam longint MAXV = 65535;
  localparam longint NONE = 64'h1_0000_0000;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  ap_ctrl_perf_monitor_if #(.NUM_CH(2), .CNT_W(16)) bus_a ();
  ap_ctrl_perf_monitor_if #(.NUM_CH(3), .CNT_W(4))  bus_b ();

  ap_ctrl_perf_monitor #(.NUM_CH(2), .CNT_W(16), .TIMEOUT(100)) u_a (
    .clock (clock), .reset (reset), .bus (bus_a.slave));
  ap_ctrl_perf_monitor #(.NUM_CH(3), .CNT_W(4), .TIMEOUT(0)) u_b (
    .clock (clock), .reset (reset), .bus (bus_b.slave));

  // Reference model for DUT A: unbounded counts, saturated only when read.
  longint m_txn[NCH], m_last[NCH], m_lmin[NCH], m_lmax[NCH], m_lsum[NCH];
  longint m_iimin[NCH], m_iimax[NCH], m_stall[NCH], m_tstart[NCH], m_lastacc[NCH];
  int     m_ph[NCH];
  bit     m_seen[NCH], m_tmo[NCH];
  longint m_cyc = 0, m_act = 0;

  function automatic longint sat(longint v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_txn[c] = 0; m_last[c] = 0; m_lmin[c] = NONE; m_lmax[c] = 0; m_lsum[c] = 0;
      m_iimin[c] = NONE; m_iimax[c] = 0; m_stall[c] = 0; m_tstart[c] = 0; m_lastacc[c] = 0;
      m_ph[c] = 0; m_seen[c] = 1'b0; m_tmo[c] = 1'b0;
    end
    m_act = 0;
  endtask

  task automatic m_record(int c, longint s);
    m_txn[c]++;
    m_last[c] = s;
    m_lsum[c] += s;
    if (s < m_lmin[c]) m_lmin[c] = s;
    if (s > m_lmax[c]) m_lmax[c] = s;
  endtask

  // Applies the rules to the inputs sampled at the current rising edge.
  task automatic model_step();
    bit fin;
    bit s, r, d, k;
    longint lat, ii;
    fin = bus_a.finish;
    if (reset) begin
      model_reset();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        s = bus_a.ap_start[c]; r = bus_a.ap_ready[c];
        d = bus_a.ap_done[c];  k = bus_a.ap_continue[c];
        if (!fin && s && r) begin
          if (m_seen[c]) begin
            ii = m_act - m_lastacc[c];
            if (ii < m_iimin[c]) m_iimin[c] = ii;
            if (ii > m_iimax[c]) m_iimax[c] = ii;
          end
          m_lastacc[c] = m_act;
          m_seen[c] = 1'b1;
        end
        case (m_ph[c])
          0: if (s) begin
            m_tstart[c] = m_cyc;
            if (d) begin
              if (!fin) m_record(c, 0);
              m_ph[c] = k ? 0 : 2;
            end else m_ph[c] = 1;
          end
          1: begin
            lat = m_cyc - m_tstart[c];
            if (!fin && lat == 100) m_tmo[c] = 1'b1;
            if (d) begin
              if (!fin) m_record(c, sat(lat));
              m_ph[c] = k ? 0 : 2;
            end
          end
          default: if (k) m_ph[c] = 0; else if (!fin) m_stall[c]++;
        endcase
      end
      if (!fin) m_act++;
    end
    m_cyc++;
  endtask

  function automatic logic [63:0] exp_stat(int c, int sel);
    longint v;
    case (sel)
      0: v = m_txn[c];
      1: v = m_last[c];
      2: v = m_lmin[c];
      3: v = m_lmax[c];
      4: v = m_lsum[c];
      5: v = m_iimin[c];
      6: v = m_iimax[c];
      default: v = m_stall[c];
    endcase
    return 64'(sat(v));
  endfunction

  function automatic logic [63:0] m_busy();
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c] = (m_ph[c] != 0);
    return v;
  endfunction

  function automatic logic [63:0] m_tmo_vec();
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c] = m_tmo[c];
    return v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic rd_a(string tag, int c, int sel, bit use_const, logic [63:0] cval);
    logic [63:0] e;
    bus_a.rd_en  = 1'b1;
    bus_a.rd_ch  = 1'(c);
    bus_a.rd_sel = 3'(sel);
    e = use_const ? cval : exp_stat(c, sel);
    tick();
    bus_a.rd_en = 1'b0;
    chk({tag, "_vld"}, 64'(bus_a.rd_valid), 64'd1);
    chk(tag, 64'(bus_a.rd_data), e);
  endtask

  task automatic rd_b(string tag, int c, int sel, logic [63:0] e);
    bus_b.rd_en  = 1'b1;
    bus_b.rd_ch  = 2'(c);
    bus_b.rd_sel = 3'(sel);
    tick();
    bus_b.rd_en = 1'b0;
    chk({tag, "_vld"}, 64'(bus_b.rd_valid), 64'd1);
    chk(tag, 64'(bus_b.rd_data), e);
  endtask

  task automatic txn_a(int c, int lat, int stall);
    bus_a.ap_start[c] = 1'b1;
    bus_a.ap_ready[c] = 1'b1;
    if (lat == 0) begin
      bus_a.ap_done[c]     = 1'b1;
      bus_a.ap_continue[c] = (stall == 0);
    end
    tick();
    bus_a.ap_start[c] = 1'b0;
    bus_a.ap_ready[c] = 1'b0;
    if (lat > 0) begin
      repeat (lat - 1) tick();
      bus_a.ap_done[c]     = 1'b1;
      bus_a.ap_continue[c] = (stall == 0);
      tick();
    end
    bus_a.ap_done[c] = 1'b0;
    repeat (stall) tick();
    if (stall > 0) begin
      bus_a.ap_continue[c] = 1'b1;
      tick();
    end
    bus_a.ap_continue[c] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    bus_a.ap_start = '0; bus_a.ap_ready = '0; bus_a.ap_done = '0; bus_a.ap_continue = '1;
    bus_a.finish = 1'b0; bus_a.rd_en = 1'b0; bus_a.rd_ch = '0; bus_a.rd_sel = '0;
    bus_b.ap_start = '0; bus_b.ap_ready = '0; bus_b.ap_done = '0; bus_b.ap_continue = '1;
    bus_b.finish = 1'b0; bus_b.rd_en = 1'b0; bus_b.rd_ch = '0; bus_b.rd_sel = '0;
    reset = 1'b1;
    tick(); tick();
    chk("rst_rd_valid", 64'(bus_a.rd_valid), 64'd0);
    chk("rst_rd_data",  64'(bus_a.rd_data),  64'd0);
    chk("rst_busy",     64'(bus_a.busy),     64'd0);
    chk("rst_timeout",  64'(bus_a.timeout),  64'd0);
    chk("rst_frozen",   64'(bus_a.frozen),   64'd0);
    reset = 1'b0;
    tick();
    rd_a("rst_lat_min", 0, 2, 1'b1, 64'hFFFF);
    rd_a("rst_ii_min",  1, 5, 1'b1, 64'hFFFF);
    rd_a("rst_txn",     0, 0, 1'b1, 64'd0);

    // Single transaction, latency 5.
    txn_a(0, 5, 0);
    chk("t1_busy_low", 64'(bus_a.busy[0]), 64'd0);
    rd_a("t1_txn",  0, 0, 1'b1, 64'd1);
    rd_a("t1_last", 0, 1, 1'b1, 64'd5);
    rd_a("t1_min",  0, 2, 1'b1, 64'd5);
    rd_a("t1_max",  0, 3, 1'b1, 64'd5);
    rd_a("t1_sum",  0, 4, 1'b1, 64'd5);

    // Accepts 4 then 8 cycles apart on channel 1.
    txn_a(1, 3, 0);
    txn_a(1, 3, 0);
    repeat (4) tick();
    txn_a(1, 3, 0);
    rd_a("t2_ii_min", 1, 5, 1'b1, 64'd4);
    rd_a("t2_ii_max", 1, 6, 1'b1, 64'd8);
    rd_a("t2_txn",    1, 0, 1'b1, 64'd3);
    rd_a("t2_sum",    1, 4, 1'b1, 64'd9);
    rd_a("t2_ch0_ii", 0, 6, 1'b0, '0);

    // Continue stall of three cycles on channel 0.
    bus_a.ap_start[0] = 1'b1; bus_a.ap_ready[0] = 1'b1;
    tick();
    bus_a.ap_start[0] = 1'b0; bus_a.ap_ready[0] = 1'b0;
    tick();
    bus_a.ap_done[0] = 1'b1; bus_a.ap_continue[0] = 1'b0;
    tick();
    bus_a.ap_done[0] = 1'b0;
    repeat (3) tick();
    chk("t3_busy_stall", 64'(bus_a.busy[0]), 64'd1);
    bus_a.ap_continue[0] = 1'b1;
    tick();
    chk("t3_busy_idle", 64'(bus_a.busy[0]), 64'd0);
    rd_a("t3_stall",   0, 7, 1'b1, 64'd3);
    rd_a("t3_ch1_txn", 1, 0, 1'b1, 64'd3);
    rd_a("t3_ch1_sum", 1, 4, 1'b1, 64'd9);

    // Timeout at latency 100, late done still recorded.
    bus_a.ap_start[0] = 1'b1; bus_a.ap_ready[0] = 1'b1;
    tick();
    bus_a.ap_start[0] = 1'b0; bus_a.ap_ready[0] = 1'b0;
    repeat (98) tick();
    chk("t4_tmo_before", 64'(bus_a.timeout[0]), 64'd0);
    tick(); tick();
    chk("t4_tmo_set", 64'(bus_a.timeout[0]), 64'd1);
    repeat (49) tick();
    bus_a.ap_done[0] = 1'b1;
    tick();
    bus_a.ap_done[0] = 1'b0;
    chk("t4_tmo_sticky", 64'(bus_a.timeout), m_tmo_vec());
    rd_a("t4_last", 0, 1, 1'b1, 64'd150);
    rd_a("t4_max",  0, 3, 1'b0, '0);
    chk("t4_tmo_hold", 64'(bus_a.timeout[0]), 64'd1);

    // Freeze mid-transaction, then reset.
    bus_a.ap_start[1] = 1'b1; bus_a.ap_ready[1] = 1'b1;
    tick();
    bus_a.ap_start[1] = 1'b0; bus_a.ap_ready[1] = 1'b0;
    tick();
    bus_a.finish = 1'b1;
    tick();
    chk("t5_frozen", 64'(bus_a.frozen), 64'd1);
    bus_a.ap_done[1] = 1'b1;
    bus_a.ap_start[0] = 1'b1; bus_a.ap_ready[0] = 1'b1;
    tick();
    bus_a.ap_done[1] = 1'b0;
    bus_a.ap_start[0] = 1'b0; bus_a.ap_ready[0] = 1'b0;
    for (int s = 0; s < 8; s++) begin
      rd_a("t5_frz_ch0", 0, s, 1'b0, '0);
      rd_a("t5_frz_ch1", 1, s, 1'b0, '0);
    end
    rd_a("t5_frz_txn1", 1, 0, 1'b1, 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_a.finish = 1'b0;
    chk("t5_rst_frozen",  64'(bus_a.frozen),  64'd0);
    chk("t5_rst_busy",    64'(bus_a.busy),    64'd0);
    chk("t5_rst_timeout", 64'(bus_a.timeout), 64'd0);
    rd_a("t5_rst_txn", 0, 0, 1'b1, 64'd0);
    rd_a("t5_rst_min", 0, 2, 1'b1, 64'hFFFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [63:0] e_vld, e_dat;
      for (int c = 0; c < NCH; c++) begin
        bus_a.ap_start[c]    = ($urandom_range(0, 2) == 0);
        bus_a.ap_ready[c]    = ($urandom_range(0, 3) != 0);
        bus_a.ap_done[c]     = ($urandom_range(0, 3) == 0);
        bus_a.ap_continue[c] = ($urandom_range(0, 2) != 0);
      end
      if ($urandom_range(0, 39) == 0) bus_a.finish = ~bus_a.finish;
      bus_a.rd_en  = ($urandom_range(0, 1) == 1);
      bus_a.rd_ch  = 1'($urandom_range(0, 1));
      bus_a.rd_sel = 3'($urandom_range(0, 7));
      e_vld = 64'(bus_a.rd_en);
      e_dat = exp_stat(int'(bus_a.rd_ch), int'(bus_a.rd_sel));
      tick();
      chk("rnd_vld", 64'(bus_a.rd_valid), e_vld);
      if (e_vld[0]) chk("rnd_data", 64'(bus_a.rd_data), e_dat);
      chk("rnd_busy", 64'(bus_a.busy), m_busy());
      chk("rnd_tmo",  64'(bus_a.timeout), m_tmo_vec());
    end
    bus_a.ap_start = '0; bus_a.ap_ready = '0; bus_a.ap_done = '0; bus_a.ap_continue = '1;
    bus_a.finish = 1'b0; bus_a.rd_en = 1'b0;
    tick();
    chk("rnd_idle_vld", 64'(bus_a.rd_valid), 64'd0);

    // Narrow counters saturate on the second instance.
    for (int t = 0; t < 20; t++) begin
      bus_b.ap_start[0] = 1'b1; bus_b.ap_ready[0] = 1'b1;
      tick();
      bus_b.ap_start[0] = 1'b0; bus_b.ap_ready[0] = 1'b0;
      tick();
      bus_b.ap_done[0] = 1'b1;
      tick();
      bus_b.ap_done[0] = 1'b0;
    end
    rd_b("t6_txn",   0, 0, 64'd15);
    rd_b("t6_sum",   0, 4, 64'd15);
    rd_b("t6_min",   0, 2, 64'd2);
    rd_b("t6_ii",    0, 6, 64'd3);
    rd_b("t6_badch", 3, 0, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
